team_05_gpio_arbiter: RTL

TEAM_05_GPIO_ARBITER -- requirements
Module: team_05_gpio_arbiter

---
 rtl/team_05_gpio_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/team_05_gpio_arbiter.sv
// Round-robin arbiter granting one of four requesters ownership of the shared user GPIO pins,
// with a bounded tenure under contention and a one-cycle contention-free turnaround between holders.
module team_05_gpio_arbiter #(
    parameter int WIDTH      = 34,
    parameter int MAX_TENURE = 64
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 en,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   req_data,
    input  logic [4*WIDTH-1:0]   req_oeb,
    output logic [3:0]           grant,
    output logic [WIDTH-1:0]     gpio_out,
    output logic [WIDTH-1:0]     gpio_oeb,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam int              CW          = (MAX_TENURE > 2) ? $clog2(MAX_TENURE) : 1;
    localparam logic [CW-1:0]   TENURE_LAST = CW'(MAX_TENURE - 1);

    state_e             state_q, state_d;
    logic [1:0]         holder_q, holder_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [CW-1:0]      tenure_q, tenure_d;
    logic [3:0]         grant_q, grant_d;
    logic [WIDTH-1:0]   gpio_out_q, gpio_out_d;
    logic [WIDTH-1:0]   gpio_oeb_q, gpio_oeb_d;
    logic               busy_q, busy_d;

    logic [1:0]         rr_idx;
    logic [1:0]         rr_winner;
    logic               rr_found;
    logic [3:0]         holder_oh;
    logic               holder_req;
    logic               tenure_expired;
    logic [WIDTH-1:0]   holder_data;
    logic [WIDTH-1:0]   holder_oeb;

    // Search starts just after the last holder, so the previous holder is visited last.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
        rr_idx    = '0;
        rr_winner = last_grant_q;
        rr_found  = 1'b0;
        for (int off = 1; off <= 4; off++) begin
            rr_idx = last_grant_q + 2'(off);
            if (!rr_found && req[rr_idx]) begin
                rr_winner = rr_idx;
                rr_found  = 1'b1;
            end
        end
    end

    assign holder_oh      = 4'b0001 << holder_q;
    assign holder_req     = req[holder_q];
    assign tenure_expired = (tenure_q == TENURE_LAST) && (|(req & ~holder_oh));
    assign holder_data    = req_data[int'(holder_q) * WIDTH +: WIDTH];
    assign holder_oeb     = req_oeb[int'(holder_q) * WIDTH +: WIDTH];

    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            holder_q     <= 2'd0;
            last_grant_q <= 2'd3;
            tenure_q     <= '0;
            grant_q      <= 4'b0000;
            gpio_out_q   <= '0;
            gpio_oeb_q   <= '1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            holder_q     <= holder_d;
            last_grant_q <= last_grant_d;
            tenure_q     <= tenure_d;
            grant_q      <= grant_d;
            gpio_out_q   <= gpio_out_d;
            gpio_oeb_q   <= gpio_oeb_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en && rr_found) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (!en)                                state_d = ST_IDLE;
                else if (!holder_req || tenure_expired) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = (en && rr_found) ? ST_GRANT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins are driven only while a grant persists; entry, release and idle all present the safe state.
    always_comb begin
        holder_d     = holder_q;
        last_grant_d = last_grant_q;
        tenure_d     = tenure_q;
        grant_d      = 4'b0000;
        gpio_out_d   = '0;
        gpio_oeb_d   = '1;
        busy_d       = (state_d != ST_IDLE);

        if (state_d == ST_GRANT) begin
            if (state_q == ST_GRANT) begin
                grant_d    = holder_oh;
                gpio_out_d = holder_data;
                gpio_oeb_d = holder_oeb;
                if (tenure_q != TENURE_LAST) tenure_d = tenure_q + CW'(1);
            end else begin
                holder_d = rr_winner;
                grant_d  = 4'b0001 << rr_winner;
                tenure_d = '0;
            end
        end

        if (state_q == ST_GRANT && state_d == ST_RELEASE) last_grant_d = holder_q;
    end

    assign grant    = grant_q;
    assign gpio_out = gpio_out_q;
    assign gpio_oeb = gpio_oeb_q;
    assign busy     = busy_q;

endmodule
